// File: rtl/paj7620_pkg.sv
// PAJ7620 responder shared definitions: FSM states, register addresses and
// gesture flag bit positions.
`timescale 1ns/1ps
package paj7620_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [DATA_W-1:0] REG_ID_L = 8'h00;
  localparam logic [DATA_W-1:0] REG_ID_H = 8'h01;
  localparam logic [DATA_W-1:0] REG_FLAG = 8'h43;
  localparam logic [DATA_W-1:0] REG_BANK = 8'hEF;

  localparam int unsigned GEST_UP       = 0;
  localparam int unsigned GEST_DOWN     = 1;
  localparam int unsigned GEST_LEFT     = 2;
  localparam int unsigned GEST_RIGHT    = 3;
  localparam int unsigned GEST_FORWARD  = 4;
  localparam int unsigned GEST_BACKWARD = 5;
  localparam int unsigned GEST_CW       = 6;
  localparam int unsigned GEST_CCW      = 7;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RD_ACKCHK,
    IGNORE
  } state_e;

endpackage

// File: rtl/paj7620_i2c_responder_line_sync.sv
// Synchronises raw SCL/SDA and flags SCL edges plus START/STOP conditions.
// Ports: clk, rst_n; scl, sda_i raw pad inputs; scl_rise, scl_fall,
// start_det, stop_det one-clk pulses; sda_s is SDA aligned with the pulses.
`timescale 1ns/1ps
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0] metastability stage, [1] synchronised level, [2] previous level
  logic [2:0] scl_pipe_q, scl_pipe_d;
  logic [2:0] sda_pipe_q, sda_pipe_d;
  logic       scl_rise_q, scl_rise_d;
  logic       scl_fall_q, scl_fall_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;
  logic       sda_s_q, sda_s_d;

  always_comb begin
    scl_pipe_d  = {scl_pipe_q[1:0], scl};
    sda_pipe_d  = {sda_pipe_q[1:0], sda_i};
    scl_rise_d  = scl_pipe_q[1] & ~scl_pipe_q[2];
    scl_fall_d  = ~scl_pipe_q[1] & scl_pipe_q[2];
    start_det_d = scl_pipe_q[1] & scl_pipe_q[2] & sda_pipe_q[2] & ~sda_pipe_q[1];
    stop_det_d  = scl_pipe_q[1] & scl_pipe_q[2] & ~sda_pipe_q[2] & sda_pipe_q[1];
    sda_s_d     = sda_pipe_q[1];
  end

  // Lines reset to the idle-bus level so reset release never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe_q  <= 3'b111;
      sda_pipe_q  <= 3'b111;
      scl_rise_q  <= 1'b0;
      scl_fall_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      sda_s_q     <= 1'b1;
    end else begin
      scl_pipe_q  <= scl_pipe_d;
      sda_pipe_q  <= sda_pipe_d;
      scl_rise_q  <= scl_rise_d;
      scl_fall_q  <= scl_fall_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      sda_s_q     <= sda_s_d;
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign sda_s     = sda_s_q;

endmodule

// File: rtl/paj7620_i2c_responder.sv
// Bus-level PAJ7620 gesture sensor stand-in: I2C slave with part ID, bank
// select and clear-on-read gesture flags.
// Ports: clk, rst_n; scl, sda_i from the bus; sda_oe pulls SDA low;
// gest_set one-clk gesture pulses; int_n low while flags pending;
// busy high during an addressed transaction.
`timescale 1ns/1ps
module paj7620_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR = 7'h73,
  parameter logic [15:0] PART_ID  = 16'h7620
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] gest_set,
  output logic       int_n,
  output logic       busy
);
  import paj7620_pkg::*;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0]  bank_q, bank_d;
  logic [DATA_W-1:0]  flags_q, flags_d;
  logic               rw_q, rw_d;
  logic               sda_oe_q, sda_oe_d;
  logic               busy_q, busy_d;
  logic               int_n_q, int_n_d;
  logic [DATA_W-1:0]  shift_in;
  logic [DATA_W-1:0]  rd_byte;
  logic               load_rd;

  // Register map seen by the master; only the bank register exists outside bank 0
  always_comb begin
    rd_byte = '0;
    if (ptr_q == REG_BANK) begin
      rd_byte = bank_q;
    end else if (bank_q == '0) begin
      case (ptr_q)
        REG_ID_L: rd_byte = PART_ID[7:0];
        REG_ID_H: rd_byte = PART_ID[15:8];
        REG_FLAG: rd_byte = flags_q;
        default:  rd_byte = '0;
      endcase
    end
  end

  // Protocol FSM. In ACK states bit_cnt tracks the ACK phase: 0 = waiting for
  // the fall that starts the ACK, 1 = ACK driven. In RD_ACKCHK: 0 = release,
  // 1 = sample master ACK, 2 = load next byte.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    bank_d    = bank_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    load_rd   = 1'b0;
    shift_in  = {shift_q[DATA_W-2:0], sda_s};

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            if (shift_in[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = shift_in[0];
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
          if (bit_cnt_q == '0) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = CNT_W'(1);
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (state_q == ADDR_ACK && rw_q) begin
              load_rd = 1'b1;
              state_d = RDATA;
            end else if (state_q == ADDR_ACK) begin
              state_d = REG;
            end else begin
              state_d = WDATA;
            end
          end
        end
        REG: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            ptr_d   = shift_in;
            state_d = REG_ACK;
          end
        end
        WDATA: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            if (ptr_q == REG_BANK) bank_d = shift_in;
            ptr_d   = ptr_q + DATA_W'(1);
            state_d = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            shift_d  = {shift_q[DATA_W-2:0], 1'b0};
            sda_oe_d = ~shift_q[DATA_W-2];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) state_d = RD_ACKCHK;
          end
        end
        RD_ACKCHK: begin
          if (scl_fall && bit_cnt_q == '0) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = CNT_W'(1);
          end else if (scl_rise && bit_cnt_q == CNT_W'(1)) begin
            if (sda_s) begin
              state_d = IGNORE;
            end else begin
              ptr_d     = ptr_q + DATA_W'(1);
              bit_cnt_d = CNT_W'(2);
            end
          end else if (scl_fall && bit_cnt_q == CNT_W'(2)) begin
            load_rd   = 1'b1;
            bit_cnt_d = '0;
            state_d   = RDATA;
          end
        end
        default: begin
        end
      endcase
    end

    if (load_rd) begin
      shift_d  = rd_byte;
      sda_oe_d = ~rd_byte[DATA_W-1];
    end
  end

  // Gesture flags: clear when the flag register is loaded for reading, but a
  // gesture arriving in that same clk is kept
  always_comb begin
    flags_d = flags_q | gest_set;
    if (load_rd && bank_q == '0 && ptr_q == REG_FLAG) flags_d = gest_set;
    int_n_d = ~|flags_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      bank_q    <= '0;
      flags_q   <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      int_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      bank_q    <= bank_d;
      flags_q   <= flags_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      int_n_q   <= int_n_d;
    end
  end

  assign sda_oe = sda_oe_q;
  assign int_n  = int_n_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_paj7620_i2c_responder.sv
// Directed bench for paj7620_i2c_responder acting as an I2C master.
`timescale 1ns/1ps
module tb_paj7620_i2c_responder;
  import paj7620_pkg::*;

  localparam int unsigned Q = 100;   // quarter SCL period, 40 clk per SCL

  logic       clk, rst_n, scl, msda, sda_i, sda_oe, int_n, busy;
  logic [7:0] gest_set;
  int         errors, checks;
  int         oe_cnt, busy_cnt;

  assign sda_i = msda & ~sda_oe;

  paj7620_i2c_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda_i    (sda_i),
    .sda_oe   (sda_oe),
    .gest_set (gest_set),
    .int_n    (int_n),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (sda_oe) oe_cnt++;
    if (busy)   busy_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic i2c_start();
    msda = 1'b1; #Q; scl = 1'b1; #Q; msda = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    msda = 1'b0; #Q; scl = 1'b1; #Q; msda = 1'b1; #Q;
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    msda = b; #Q; scl = 1'b1; #Q; r = sda_i; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_wr(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic i2c_rd(input logic mack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      i2c_bit(1'b1, r);
      d = {d[6:0], r};
    end
    i2c_bit(~mack, r);
  endtask

  // Full pointer-set + single-byte read transaction
  task automatic read_reg(input logic [7:0] ptr, output logic [7:0] d, output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    i2c_wr(8'hE6, a); if (!a) nacks++;
    i2c_wr(ptr, a);   if (!a) nacks++;
    i2c_start();
    i2c_wr(8'hE7, a); if (!a) nacks++;
    i2c_rd(1'b0, d);
    i2c_stop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; msda = 1'b1; gest_set = '0;
    #20;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (int_n !== 1'b1)  begin errors++; $display("FAIL reset_int_n: got %b expected 1", int_n); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    #30 rst_n = 1'b1;
    #100;
    checks++; if (sda_oe !== 1'b0 || busy !== 1'b0 || int_n !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: got oe=%b busy=%b int_n=%b expected 0 0 1", sda_oe, busy, int_n);
    end
  endtask

  task automatic test_bank_write();
    logic a0, a1, a2;
    logic [7:0] d;
    int n;
    i2c_start();
    i2c_wr(8'hE6, a0); i2c_wr(8'hEF, a1); i2c_wr(8'h01, a2);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL bank_write_acks: got %b expected 111", {a0, a1, a2}); end
    read_reg(8'hEF, d, n);
    checks++; if (d !== 8'h01 || n != 0) begin errors++; $display("FAIL bank_readback: got %h nacks=%0d expected 01 nacks=0", d, n); end
    read_reg(8'h00, d, n);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL bank1_id_low: got %h expected 00", d); end
    i2c_start();
    i2c_wr(8'hE6, a0); i2c_wr(8'hEF, a1); i2c_wr(8'h00, a2);
    i2c_stop();
    read_reg(8'hEF, d, n);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL bank_restore: got %h expected 00", d); end
  endtask

  task automatic test_part_id();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    i2c_start();
    i2c_wr(8'hE6, a0); i2c_wr(8'h00, a1);
    i2c_start();
    i2c_wr(8'hE7, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL part_id_acks: got %b expected 111", {a0, a1, a2}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL part_id_busy: got %b expected 1", busy); end
    i2c_rd(1'b1, d0);
    i2c_rd(1'b0, d1);
    checks++; if (d0 !== 8'h20) begin errors++; $display("FAIL part_id_low: got %h expected 20", d0); end
    checks++; if (d1 !== 8'h76) begin errors++; $display("FAIL part_id_high: got %h expected 76", d1); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL release_after_nack: got %b expected 0", sda_oe); end
    i2c_stop();
    #Q;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_gesture_clear();
    logic [7:0] d;
    int n;
    @(negedge clk) gest_set = 8'(1 << GEST_LEFT);
    @(negedge clk) gest_set = '0;
    @(negedge clk);
    checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL int_low_on_gesture: got %b expected 0", int_n); end
    read_reg(REG_FLAG, d, n);
    checks++; if (d !== 8'h04 || n != 0) begin errors++; $display("FAIL flag_read: got %h nacks=%0d expected 04 nacks=0", d, n); end
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL int_after_clear: got %b expected 1", int_n); end
    read_reg(REG_FLAG, d, n);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL flag_cleared: got %h expected 00", d); end
  endtask

  task automatic test_set_wins();
    logic a0, a1, a2;
    logic [7:0] d;
    int n;
    @(negedge clk) gest_set = 8'(1 << GEST_DOWN);
    @(negedge clk) gest_set = '0;
    i2c_start();
    i2c_wr(8'hE6, a0); i2c_wr(REG_FLAG, a1);
    i2c_start();
    // Flags load 3.5 clk after the raw SCL fall that ends the address ACK
    fork
      i2c_wr(8'hE7, a2);
      begin
        repeat (9) @(negedge scl);
        #30 gest_set = 8'(1 << GEST_UP);
        #10 gest_set = '0;
      end
    join
    i2c_rd(1'b0, d);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL set_wins_acks: got %b expected 111", {a0, a1, a2}); end
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL set_wins_read: got %h expected 02", d); end
    checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL set_wins_int: got %b expected 0", int_n); end
    read_reg(REG_FLAG, d, n);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL set_wins_survivor: got %h expected 01", d); end
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL set_wins_int_final: got %b expected 1", int_n); end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1, a2;
    int oe_base, busy_base;
    oe_base = oe_cnt; busy_base = busy_cnt;
    i2c_start();
    i2c_wr(8'hA0, a0); i2c_wr(8'h55, a1); i2c_wr(8'h00, a2);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL mismatch_acks: got %b expected 000", {a0, a1, a2}); end
    checks++; if (oe_cnt != oe_base) begin errors++; $display("FAIL mismatch_sda_oe: got %0d driven clks expected 0", oe_cnt - oe_base); end
    checks++; if (busy_cnt != busy_base) begin errors++; $display("FAIL mismatch_busy: got %0d busy clks expected 0", busy_cnt - busy_base); end
  endtask

  task automatic test_reset_midread();
    logic a0, a1, a2, r;
    logic [7:0] d;
    int oe_base;
    i2c_start();
    i2c_wr(8'hE6, a0); i2c_wr(8'h00, a1);
    i2c_start();
    i2c_wr(8'hE7, a2);
    msda = 1'b1; #Q; scl = 1'b1; #Q;
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL midread_driving: got %b expected 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midread_async_release: got %b expected 0", sda_oe); end
    #9 rst_n = 1'b1;
    #(Q - 10) scl = 1'b0; #Q;
    oe_base = oe_cnt;
    for (int i = 0; i < 8; i++) i2c_bit(1'b1, r);
    checks++; if (oe_cnt != oe_base || busy !== 1'b0) begin
      errors++; $display("FAIL no_response_without_start: got %0d driven clks busy=%b expected 0 0", oe_cnt - oe_base, busy);
    end
    i2c_stop();
    i2c_start();
    i2c_wr(8'hE7, a0);
    i2c_rd(1'b0, d);
    i2c_stop();
    checks++; if (a0 !== 1'b1 || d !== 8'h20) begin errors++; $display("FAIL resume_after_reset: got ack=%b data=%h expected 1 20", a0, d); end
  endtask

  initial begin
    errors = 0; checks = 0;
    test_reset();
    test_bank_write();
    test_part_id();
    test_gesture_clear();
    test_set_wins();
    test_addr_mismatch();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
